// File: rtl/or_gate_n_inputs_sync_if.sv
// Request bundle for or_gate_n_inputs_sync: raw lines and qualifiers in,
// registered pending/result/first_idx out.
interface or_gate_n_inputs_sync_if #(
  parameter int NR_OF_INPUTS = 8
);
  logic [NR_OF_INPUTS-1:0] inputs;
  logic [NR_OF_INPUTS-1:0] enable;
  logic [NR_OF_INPUTS-1:0] clear;
  logic [NR_OF_INPUTS-1:0] pending;
  logic                    result;
  logic [5:0]              first_idx;

  modport master (
    output inputs,
    output enable,
    output clear,
    input  pending,
    input  result,
    input  first_idx
  );

  modport slave (
    input  inputs,
    input  enable,
    input  clear,
    output pending,
    output result,
    output first_idx
  );
endinterface

// File: rtl/or_gate_n_inputs_sync.sv
// N-input registered OR with bubbles, sticky edge capture, enable, W1C.
// Optional two-flop input synchroniser: define OR_GATE_SYNC_INPUT_EN.
module or_gate_n_inputs_sync #(
  parameter int          NR_OF_INPUTS = 8,
  parameter logic [63:0] BubblesMask  = 64'h0,
  parameter logic [63:0] EdgeMask     = 64'h0
) (
  input logic sysclk,
  input logic sys_rst,
  or_gate_n_inputs_sync_if.slave bus
);
  localparam int N = NR_OF_INPUTS;
  localparam logic [N-1:0] BUB = BubblesMask[N-1:0];
  localparam logic [N-1:0] EDG = EdgeMask[N-1:0];

  logic [N-1:0] samp;
  logic [N-1:0] lvl;
  logic [N-1:0] rise;
  logic [N-1:0] qual;
  logic [N-1:0] prev_q;
  logic [N-1:0] pend_q, pend_d;
  logic         res_q, res_d;
  logic [5:0]   idx_q, idx_d;

`ifdef OR_GATE_SYNC_INPUT_EN
  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.inputs;
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = bus.inputs;
`endif

  assign lvl  = samp ^ BUB;
  assign rise = lvl & ~prev_q;

  // Edge set wins over a simultaneous clear.
  always_comb begin
    pend_d = (EDG & (rise | (pend_q & ~bus.clear)))
           | (~EDG & lvl);
    qual   = pend_d & bus.enable;
    res_d  = |qual;
    idx_d  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (qual[i]) idx_d = 6'(i);
    end
  end

  // prev resets high so idle-high lines do not fake an edge.
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      prev_q <= '1;
      pend_q <= '0;
      res_q  <= 1'b0;
      idx_q  <= '0;
    end else begin
      prev_q <= lvl;
      pend_q <= pend_d;
      res_q  <= res_d;
      idx_q  <= idx_d;
    end
  end

  assign bus.pending   = pend_q;
  assign bus.result    = res_q;
  assign bus.first_idx = idx_q;
endmodule

// File: doc/or_gate_n_inputs_sync.md
# or_gate_n_inputs_sync

Parametrised, clocked successor to the fixed 3-input OR gate: N request inputs with per-input inversion (bubbles), per-input level or sticky rising-edge capture, per-input enable, write-one-to-clear, and a registered OR result plus lowest-pending-index encoder. It sits between asynchronous or multi-source request lines (interrupt, bus-error, wait sources) and the control logic that consumes a single qualified request.

## Interface
Parameters:
- NR_OF_INPUTS, 8, number of inputs; legal 2..64.
- BubblesMask, 64'h0, bit i = 1 inverts input i before any other processing; bits at NR_OF_INPUTS and above ignored.
- EdgeMask, 64'h0, bit i = 1 makes input i sticky rising-edge captured; 0 makes it level.

Ports (one clock; reset is asynchronous and active-high):
- sysclk  in  1  clock, all state on rising edge.
- sys_rst  in  1  asynchronous active-high reset.
- inputs  in  NR_OF_INPUTS  raw request lines.
- enable  in  NR_OF_INPUTS  per-input qualifier for result/first_idx; does not gate capture.
- clear  in  NR_OF_INPUTS  write-one-to-clear for sticky bits; ignored for level inputs.
- pending  out  NR_OF_INPUTS  registered per-input status (unqualified by enable).
- result  out  1  registered OR of (pending & enable).
- first_idx  out  6  lowest i with pending[i] & enable[i]; 0 when none.

## Operation
- real[i] = inputs[i] XOR BubblesMask[i] (sampled input, see Configuration).
- prev register holds real from previous edge; rise[i] = real[i] & ~prev[i].
- Level input (EdgeMask[i]=0): pending[i] <= real[i]; clear[i] has no effect.
- Edge input (EdgeMask[i]=1): pending[i] <= rise[i] | (pending[i] & ~clear[i]). Set wins over simultaneous clear.
- result and first_idx computed from next-state pending and current enable, registered in the same edge, so always consistent with pending.
- first_idx: priority encoder, index 0 highest priority; 0 also when nothing pending (disambiguate with result).
- Reset values: pending 0, result 0, first_idx 0, prev all ones (no spurious edge on first sample after reset, including bubbled inputs idling high), synchroniser flops 0.
- Reset asserted mid-operation clears all sticky state immediately; released sticky edges lost during reset are not recovered.

## Timing
- Latency input -> pending/result/first_idx: 1 sysclk edge (3 with OR_GATE_SYNC_INPUT_EN).
- enable change -> result/first_idx: 1 edge; pending unaffected.
- clear pulse of 1 cycle removes sticky bit at the next edge; result drops at same edge if no other enabled pending.
- Edge input held high: one capture only; a new capture requires a low sample between.
- Pulses shorter than one sysclk period may be missed; not a supported input.

## Configuration
- OR_GATE_SYNC_INPUT_EN defined: inputs pass through a two-flop synchroniser (reset 0) before bubble inversion; latency +2 edges; safe for asynchronous sources.
- Undefined: inputs sampled directly by the prev/pending logic; caller guarantees sysclk-synchronous inputs.

## Test plan
- Reset: assert sys_rst with inputs=8'hFF, BubblesMask=0 -> pending=0, result=0, first_idx=0 during reset; release -> pending=8'hFF, result=1, first_idx=0 one edge later (enable=8'hFF).
- Bubbles: BubblesMask=8'h01, inputs=8'h01, enable=8'h01 -> result=0; inputs=8'h00 -> result=1 next edge.
- Sticky edge: EdgeMask=8'h10, inputs[4] 0->1 for one cycle then 0 -> pending=8'h10 holds; clear=8'h10 one cycle -> pending=0, result=0 next edge.
- Set/clear collision: rising edge on input 4 in same cycle as clear[4]=1 -> pending[4]=1 after edge.
- Priority/enable: pending=8'h28, enable=8'hFF -> first_idx=3; enable=8'h20 -> first_idx=5, result=1; enable=0 -> result=0, first_idx=0.
- With OR_GATE_SYNC_INPUT_EN: level input 0 rises -> pending[0]=1 exactly 3 edges later.
